m_memory: RTL and testbench



---
 rtl/m_memory_pkg.sv | 13 +
 rtl/m_memory_ram.sv | 40 ++++
 rtl/m_memory.sv | 45 ++++
 tb/tb_m_memory.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/m_memory_pkg.sv
// Shared constants for the main data memory. The memory-map manager and the bench
// use the same values.
package m_memory_pkg;

  localparam int unsigned MEM_DATA_W = 8;
  localparam int unsigned MEM_ADDR_W = 19;

  // CPU byte-address window served by this RAM; the manager subtracts MAIN_ST.
  localparam int unsigned MAIN_ST    = 32'h30000;
  localparam int unsigned MAIN_END   = 32'h7FFFF;
  localparam int unsigned MAIN_DEPTH = MAIN_END - MAIN_ST + 1;

endpackage

// File: rtl/m_memory_ram.sv
// Storage array with a registered read port. Read-during-write to the same word returns
// the pre-write contents.
module m_memory_ram
  import m_memory_pkg::*;
#(
  parameter int unsigned DATA_W = MEM_DATA_W,
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DEPTH  = 2 ** MEM_ADDR_W
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_clear,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] q
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;

  assign wr_idx = wr_addr[IDX_W-1:0];
  assign rd_idx = rd_addr[IDX_W-1:0];

  // Both updates in one block so the read sees the old word on a same-address write.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
    if (rd_clear) begin
      q <= '0;
    end else begin
      q <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/m_memory.sv
// Main data memory: simple dual-port synchronous RAM with range checking and
// synchronous reset of the read register. Stored data survives reset.
module m_memory
  import m_memory_pkg::*;
#(
  parameter int unsigned DATA_W = MEM_DATA_W,
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DEPTH  = 2 ** MEM_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] rdaddress,
  input  logic [ADDR_W-1:0] wraddress,
  input  logic              wren,
  output logic [DATA_W-1:0] q
);

  logic wr_in_range;
  logic rd_in_range;
  logic wr_en;
  logic rd_clear;

  assign wr_in_range = 32'(wraddress) < DEPTH;
  assign rd_in_range = 32'(rdaddress) < DEPTH;

  // Out-of-range reads return zero rather than aliasing onto implemented words.
  assign wr_en    = wren & ~reset & wr_in_range;
  assign rd_clear = reset | ~rd_in_range;

  m_memory_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wraddress),
    .wr_data (data),
    .rd_clear(rd_clear),
    .rd_addr (rdaddress),
    .q       (q)
  );

endmodule

// File: tb/tb_m_memory.sv
// Directed vector bench for m_memory, instantiated with the main-window depth.
module tb_m_memory;
  import m_memory_pkg::*;

  logic                  clock;
  logic                  reset;
  logic [MEM_DATA_W-1:0] data;
  logic [MEM_ADDR_W-1:0] rdaddress;
  logic [MEM_ADDR_W-1:0] wraddress;
  logic                  wren;
  logic [MEM_DATA_W-1:0] q;

  int errors = 0;
  int checks = 0;

  m_memory #(
    .DATA_W(MEM_DATA_W),
    .ADDR_W(MEM_ADDR_W),
    .DEPTH (MAIN_DEPTH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .data     (data),
    .rdaddress(rdaddress),
    .wraddress(wraddress),
    .wren     (wren),
    .q        (q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string                 name;
    logic                  rst;
    logic                  we;
    logic [MEM_ADDR_W-1:0] wa;
    logic [MEM_DATA_W-1:0] wd;
    logic [MEM_ADDR_W-1:0] ra;
    logic [MEM_DATA_W-1:0] exp_q;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic rst, input logic we,
                     input logic [MEM_ADDR_W-1:0] wa, input logic [MEM_DATA_W-1:0] wd,
                     input logic [MEM_ADDR_W-1:0] ra, input logic [MEM_DATA_W-1:0] exp_q);
    vec_t v;
    v.name = name; v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.ra = ra; v.exp_q = exp_q;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [MEM_DATA_W-1:0] exp_q);
    checks++;
    if (q !== exp_q) begin
      errors++;
      $display("FAIL %s: q=%h expected=%h at %0t", name, q, exp_q, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    reset     = v.rst;
    wren      = v.we;
    wraddress = v.wa;
    data      = v.wd;
    rdaddress = v.ra;
  endtask

  initial begin
    reset = 1'b1; wren = 1'b0; wraddress = '0; data = '0; rdaddress = '0;

    //   name            rst we  wa        wd     ra        exp q
    add("reset0",        1,  0, 19'h0,    8'h00, 19'h0,    8'h00);
    add("reset1",        1,  0, 19'h0,    8'h00, 19'h0,    8'h00);
    add("pwrup_lo",      0,  0, 19'h0,    8'h00, 19'h00000, 8'h00);
    add("pwrup_hi",      0,  0, 19'h0,    8'h00, 19'h4FFFF, 8'h00);
    add("wr_a5",         0,  1, 19'h10,   8'hA5, 19'h00000, 8'h00);
    add("wr_3c_rd_a5",   0,  1, 19'h4FFFF, 8'h3C, 19'h00010, 8'hA5);
    add("rd_3c",         0,  0, 19'h0,    8'h00, 19'h4FFFF, 8'h3C);
    add("wr_11",         0,  1, 19'h123,  8'h11, 19'h4FFFF, 8'h3C);
    add("rdw_old",       0,  1, 19'h123,  8'h22, 19'h00123, 8'h11);
    add("rdw_new",       0,  0, 19'h0,    8'h00, 19'h00123, 8'h22);
    add("wr_55",         0,  1, 19'h100,  8'h55, 19'h00000, 8'h00);
    add("indep_rd_55",   0,  1, 19'h200,  8'h77, 19'h00100, 8'h55);
    add("indep_rd_77",   0,  0, 19'h0,    8'h00, 19'h00200, 8'h77);
    add("wr_99",         0,  1, 19'h50,   8'h99, 19'h00123, 8'h22);
    add("rst_q0_a",      1,  1, 19'h50,   8'hEE, 19'h00050, 8'h00);
    add("rst_q0_b",      1,  1, 19'h50,   8'hEE, 19'h00050, 8'h00);
    add("post_rst_99",   0,  0, 19'h0,    8'h00, 19'h00050, 8'h99);
    add("oor_wr",        0,  1, 19'h60000, 8'hFF, 19'h4FFFF, 8'h3C);
    add("oor_rd",        0,  0, 19'h0,    8'h00, 19'h60000, 8'h00);
    add("oor_rd_top",    0,  0, 19'h0,    8'h00, 19'h7FFFF, 8'h00);
    add("hi_unchanged",  0,  0, 19'h0,    8'h00, 19'h4FFFF, 8'h3C);
    add("lo_unchanged",  0,  0, 19'h0,    8'h00, 19'h00010, 8'hA5);

    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i]);
      @(posedge clock);
      #1;
      check(vecs[i].name, vecs[i].exp_q);
    end

    // q must hold between edges even when the read address changes.
    @(negedge clock);
    reset = 1'b0; wren = 1'b0; rdaddress = 19'h00123;
    #2;
    check("hold_before_edge", 8'hA5);
    @(posedge clock);
    #1;
    check("after_edge_22", 8'h22);

    // Reset held over several edges keeps q at zero, then normal read resumes.
    @(negedge clock);
    reset = 1'b1; rdaddress = 19'h00100;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      check("rst_hold", 8'h00);
    end
    @(negedge clock);
    reset = 1'b0;
    #2;
    check("rst_release_hold", 8'h00);
    @(posedge clock);
    #1;
    check("rst_release_rd", 8'h55);

    // Unknown wren must not corrupt the word at the write address.
    @(negedge clock);
    wren = 1'bx; wraddress = 19'h00200; data = 8'hDE; rdaddress = 19'h00000;
    @(posedge clock);
    @(negedge clock);
    wren = 1'b0; rdaddress = 19'h00200;
    @(posedge clock);
    #1;
    check("x_wren_no_write", 8'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
